fetcher_icache: RTL and testbench
=================================

Name: fetcher_icache

Overview:
Instruction fetch stage for one core, directly upstream of the core scheduler. When the core is in FETCH, it looks up current_pc in a small direct-mapped instruction cache. On a miss it reads program memory through a valid/ready handshake. It then presents the instruction and reports FETCH_DONE (fetcher_state == 3'd3), which the scheduler waits on before entering DECODE.

Parameters:
ADDR_WIDTH, 8, program memory address width; matches the scheduler's current_pc width.
INSTR_WIDTH, 16, instruction word width.
CACHE_LINES, 4, number of direct-mapped lines, one instruction each; power of two, >= 2.
CACHE_EN, 1, 1 enables the cache; 0 forces every fetch to memory and never writes lines.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
core_state  input  core_state_t (gpu_pkg)  current scheduler state
current_pc  input  ADDR_WIDTH  PC to fetch; stable while core_state == FETCH
flush  input  1  synchronous cache invalidate; pulsed by the core on kernel start
mem_read_valid  output  1  program memory read request
mem_read_address  output  ADDR_WIDTH  request address
mem_read_ready  input  1  memory response strobe; data valid in the same cycle
mem_read_data  input  INSTR_WIDTH  returned instruction
fetcher_state  output  3  0 = IDLE, 1 = FETCHING, 3 = DONE; encoding 2 is never produced
instruction  output  INSTR_WIDTH  fetched instruction, held until the next fetch completes

Behaviour:
- Reset, async and asserted: fetcher_state = 0, mem_read_valid = 0, mem_read_address = 0, instruction = 0, all line valid bits = 0. Reset mid-fetch abandons the request; mem_read_valid drops immediately.
- Address split: index = current_pc[log2(CACHE_LINES)-1:0]; tag = remaining upper bits. Each line stores valid, tag and data.
- IDLE with core_state == FETCH:
  - Hit (CACHE_EN, valid, tag match): next edge sets instruction = line data and fetcher_state = DONE. No memory request is made. Latency is 1 cycle.
  - Miss: next edge sets mem_read_valid = 1, mem_read_address = current_pc and fetcher_state = FETCHING.
- IDLE with any other core_state: no action.
- FETCHING:
  - mem_read_valid and mem_read_address are held stable until an edge with mem_read_ready = 1.
  - At that edge: instruction = mem_read_data, mem_read_valid = 0, fetcher_state = DONE.
  - If CACHE_EN, the same edge writes line[index] with valid = 1, tag and data.
  - mem_read_ready while not FETCHING is ignored.
  - An in-flight request is never abandoned except by reset, even if core_state leaves FETCH.
- DONE:
  - Holds instruction.
  - On an edge where core_state != FETCH, returns to IDLE. The normal sequence is DONE, then the scheduler enters DECODE, then IDLE.
  - instruction is not modified leaving DONE; the decoder reads it during DECODE.
- Illegal state register value (2, 4-7): next edge goes to IDLE, deasserts mem_read_valid, leaves instruction unchanged.
- flush: on the edge where it is high, all valid bits clear.
  - If a fill lands on the same edge, flush wins and the line ends invalid. The fetched instruction is still delivered.
  - flush does not alter fetcher_state or an outstanding request.
- Lookup during a fetch that hits, concurrent with flush asserted in that cycle: treated as a hit, because the lookup uses pre-edge valid bits.
- CACHE_EN = 0: every FETCH takes the miss path; valid bits stay 0.

Test Plan:
- Cold miss: reset, flush, core_state = FETCH, current_pc = 0x05, memory returns 0xA123 on the 3rd cycle after valid. Required: valid high with address 0x05 until that edge, then instruction = 0xA123, fetcher_state = 3, valid = 0.
- Hit: repeat FETCH of 0x05. Required: fetcher_state = 3 one cycle after FETCH, instruction = 0xA123, mem_read_valid stays 0.
- Conflict eviction (CACHE_LINES = 4): fetch 0x01 (data 0x1111), then 0x05 (data 0x5555), then 0x01 again. Required: all three are misses, and the third returns 0x1111 from memory.
- Flush: after a cached 0x05, pulse flush, then FETCH 0x05. Required: miss and memory request issued. Flush on the same edge as the fill of 0x02: instruction is delivered, and a following FETCH of 0x02 misses.
- DONE exit: in DONE, core_state stays FETCH for 2 extra cycles, then DECODE. Required: fetcher_state holds 3 throughout, returns to 0 the cycle after DECODE, instruction unchanged.
- Reset mid-FETCHING: assert rst_n = 0. Required: mem_read_valid = 0 and fetcher_state = 0 immediately. The subsequent FETCH of the same PC misses.

Source files
------------

// File: rtl/fetcher_icache.sv
// Instruction fetch stage with a small direct-mapped instruction cache in front of program memory.
// A hit completes in one cycle; a miss issues a valid/ready read and fills the line on return.
package gpu_pkg;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    REQUEST = 3'd3,
    WAIT    = 3'd4,
    EXECUTE = 3'd5,
    UPDATE  = 3'd6,
    DONE    = 3'd7
  } core_state_t;
endpackage

module fetcher_icache
  import gpu_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int INSTR_WIDTH = 16,
  parameter int CACHE_LINES = 4,
  parameter int CACHE_EN    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  core_state_t            core_state,
  input  logic [ADDR_WIDTH-1:0]  current_pc,
  input  logic                   flush,
  output logic                   mem_read_valid,
  output logic [ADDR_WIDTH-1:0]  mem_read_address,
  input  logic                   mem_read_ready,
  input  logic [INSTR_WIDTH-1:0] mem_read_data,
  output logic [2:0]             fetcher_state,
  output logic [INSTR_WIDTH-1:0] instruction
);

  localparam int IDX_W = $clog2(CACHE_LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCHING = 3'd1,
    ST_DONE     = 3'd3
  } fetch_state_e;

  fetch_state_e           state_q, state_d;
  logic                   mem_valid_q, mem_valid_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [CACHE_LINES-1:0] line_valid_q, line_valid_d;

  logic [TAG_W-1:0]       tag_mem  [CACHE_LINES];
  logic [INSTR_WIDTH-1:0] data_mem [CACHE_LINES];

  logic [IDX_W-1:0] lookup_idx, fill_idx;
  logic [TAG_W-1:0] lookup_tag, fill_tag;
  logic             hit;
  logic             fill_en;

  assign lookup_idx = current_pc[IDX_W-1:0];
  assign lookup_tag = current_pc[ADDR_WIDTH-1:IDX_W];
  // The fill targets the address actually requested, which is held in mem_addr_q.
  assign fill_idx   = mem_addr_q[IDX_W-1:0];
  assign fill_tag   = mem_addr_q[ADDR_WIDTH-1:IDX_W];

  // Lookup uses pre-edge valid bits, so a flush in the same cycle does not cancel a hit.
  assign hit = (CACHE_EN != 0) && line_valid_q[lookup_idx]
               && (tag_mem[lookup_idx] == lookup_tag);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    instr_d     = instr_q;
    fill_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (core_state == FETCH) begin
          if (hit) begin
            instr_d = data_mem[lookup_idx];
            state_d = ST_DONE;
          end else begin
            mem_valid_d = 1'b1;
            mem_addr_d  = current_pc;
            state_d     = ST_FETCHING;
          end
        end
      end
      ST_FETCHING: begin
        if (mem_read_ready) begin
          instr_d     = mem_read_data;
          mem_valid_d = 1'b0;
          state_d     = ST_DONE;
          fill_en     = (CACHE_EN != 0);
        end
      end
      ST_DONE: begin
        if (core_state != FETCH) state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase

    line_valid_d = line_valid_q;
    if (fill_en) line_valid_d[fill_idx] = 1'b1;
    if (flush)   line_valid_d = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mem_valid_q  <= 1'b0;
      mem_addr_q   <= '0;
      instr_q      <= '0;
      line_valid_q <= '0;
    end else begin
      state_q      <= state_d;
      mem_valid_q  <= mem_valid_d;
      mem_addr_q   <= mem_addr_d;
      instr_q      <= instr_d;
      line_valid_q <= line_valid_d;
    end
  end

  // NOTE: tag/data storage is not reset; the valid bits alone make stale contents unreachable.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem_read_data;
    end
  end

  assign mem_read_valid   = mem_valid_q;
  assign mem_read_address = mem_addr_q;
  assign fetcher_state    = state_q;
  assign instruction      = instr_q;

endmodule

// File: tb/tb_fetcher_icache.sv
// Directed bench for fetcher_icache: misses, hits, conflict eviction, flush races, DONE exit, reset.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetcher_icache;
  import gpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  core_state_t core_state;
  logic [7:0]  current_pc;
  logic        flush;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready;
  logic [15:0] mem_read_data;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;

  int total = 0;
  int bad   = 0;

  fetcher_icache #(
    .ADDR_WIDTH(8), .INSTR_WIDTH(16), .CACHE_LINES(4), .CACHE_EN(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .core_state(core_state), .current_pc(current_pc),
    .flush(flush), .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .fetcher_state(fetcher_state), .instruction(instruction)
  );

  always #5 clk = ~clk;

  // Miss sequence: memory answers on the waits-th cycle after valid; DONE is held for hold extra FETCH cycles.
  task automatic fetch_miss(input logic [7:0] pc, input logic [15:0] data,
                            input int waits, input int hold, input string name);
    @(negedge clk);
    core_state = FETCH; current_pc = pc;
    @(negedge clk);
    total++;
    if (fetcher_state !== 3'd1 || mem_read_valid !== 1'b1 || mem_read_address !== pc) begin
      bad++;
      $display("FAIL %s_request: state=%0d valid=%b addr=%h, required state=1 valid=1 addr=%h",
               name, fetcher_state, mem_read_valid, mem_read_address, pc);
    end
    for (int i = 1; i < waits; i++) begin
      @(negedge clk);
      total++;
      if (fetcher_state !== 3'd1 || mem_read_valid !== 1'b1 || mem_read_address !== pc) begin
        bad++;
        $display("FAIL %s_hold%0d: state=%0d valid=%b addr=%h, required state=1 valid=1 addr=%h",
                 name, i, fetcher_state, mem_read_valid, mem_read_address, pc);
      end
    end
    mem_read_ready = 1'b1; mem_read_data = data;
    @(negedge clk);
    mem_read_ready = 1'b0; mem_read_data = 16'hDEAD;
    total++;
    if (fetcher_state !== 3'd3 || mem_read_valid !== 1'b0 || instruction !== data) begin
      bad++;
      $display("FAIL %s_done: state=%0d valid=%b instr=%h, required state=3 valid=0 instr=%h",
               name, fetcher_state, mem_read_valid, instruction, data);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      total++;
      if (fetcher_state !== 3'd3 || instruction !== data) begin
        bad++;
        $display("FAIL %s_done_hold%0d: state=%0d instr=%h, required state=3 instr=%h",
                 name, i, fetcher_state, instruction, data);
      end
    end
    core_state = DECODE;
    @(negedge clk);
    core_state = IDLE;
    total++;
    if (fetcher_state !== 3'd0 || instruction !== data) begin
      bad++;
      $display("FAIL %s_exit: state=%0d instr=%h, required state=0 instr=%h",
               name, fetcher_state, instruction, data);
    end
  endtask

  task automatic fetch_hit(input logic [7:0] pc, input logic [15:0] data, input string name);
    @(negedge clk);
    core_state = FETCH; current_pc = pc;
    @(negedge clk);
    total++;
    if (fetcher_state !== 3'd3 || mem_read_valid !== 1'b0 || instruction !== data) begin
      bad++;
      $display("FAIL %s: state=%0d valid=%b instr=%h, required state=3 valid=0 instr=%h",
               name, fetcher_state, mem_read_valid, instruction, data);
    end
    core_state = DECODE;
    @(negedge clk);
    core_state = IDLE;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; core_state = IDLE; current_pc = 8'h00; flush = 1'b0;
    mem_read_ready = 1'b0; mem_read_data = 16'h0000;
    #3;
    total++;
    if (fetcher_state !== 3'd0 || mem_read_valid !== 1'b0 || mem_read_address !== 8'h00 ||
        instruction !== 16'h0000) begin
      bad++;
      $display("FAIL reset: state=%0d valid=%b addr=%h instr=%h, required all zero",
               fetcher_state, mem_read_valid, mem_read_address, instruction);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // A stray response while idle must be ignored.
    mem_read_ready = 1'b1; mem_read_data = 16'hBEEF;
    @(negedge clk);
    mem_read_ready = 1'b0;
    total++;
    if (fetcher_state !== 3'd0 || instruction !== 16'h0000) begin
      bad++;
      $display("FAIL stray_ready: state=%0d instr=%h, required state=0 instr=0000",
               fetcher_state, instruction);
    end
  endtask

  task automatic test_cold_miss();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    fetch_miss(8'h05, 16'hA123, 3, 0, "cold_miss");
  endtask

  task automatic test_hit();
    fetch_hit(8'h05, 16'hA123, "hit_05");
  endtask

  task automatic test_eviction();
    fetch_miss(8'h01, 16'h1111, 1, 0, "evict_01");
    fetch_miss(8'h05, 16'h5555, 2, 0, "evict_05");
    fetch_miss(8'h01, 16'h1111, 1, 0, "evict_01_again");
  endtask

  task automatic test_flush();
    fetch_miss(8'h05, 16'h5555, 1, 0, "flush_prefill");
    fetch_hit(8'h05, 16'h5555, "flush_prehit");
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    fetch_miss(8'h05, 16'h5A5A, 2, 0, "after_flush");
    // Flush lands on the same edge as the fill of 0x02.
    @(negedge clk);
    core_state = FETCH; current_pc = 8'h02;
    @(negedge clk);
    mem_read_ready = 1'b1; mem_read_data = 16'h2222; flush = 1'b1;
    @(negedge clk);
    mem_read_ready = 1'b0; flush = 1'b0;
    total++;
    if (fetcher_state !== 3'd3 || instruction !== 16'h2222) begin
      bad++;
      $display("FAIL flush_fill_deliver: state=%0d instr=%h, required state=3 instr=2222",
               fetcher_state, instruction);
    end
    core_state = DECODE;
    @(negedge clk);
    core_state = IDLE;
    fetch_miss(8'h02, 16'h2222, 1, 0, "flush_fill_miss");
  endtask

  task automatic test_flush_hit_race();
    @(negedge clk);
    core_state = FETCH; current_pc = 8'h02; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++;
    if (fetcher_state !== 3'd3 || mem_read_valid !== 1'b0 || instruction !== 16'h2222) begin
      bad++;
      $display("FAIL flush_hit_race: state=%0d valid=%b instr=%h, required state=3 valid=0 instr=2222",
               fetcher_state, mem_read_valid, instruction);
    end
    core_state = DECODE;
    @(negedge clk);
    core_state = IDLE;
    fetch_miss(8'h02, 16'h2B2B, 1, 0, "race_then_miss");
  endtask

  task automatic test_done_exit();
    fetch_miss(8'h03, 16'h3333, 1, 2, "done_exit");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    core_state = FETCH; current_pc = 8'h09;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (fetcher_state !== 3'd0 || mem_read_valid !== 1'b0 || instruction !== 16'h0000) begin
      bad++;
      $display("FAIL reset_mid: state=%0d valid=%b instr=%h, required state=0 valid=0 instr=0000",
               fetcher_state, mem_read_valid, instruction);
    end
    core_state = IDLE;
    @(negedge clk);
    rst_n = 1'b1;
    fetch_miss(8'h09, 16'h9999, 2, 0, "after_reset_09");
    fetch_miss(8'h02, 16'h2C2C, 1, 0, "after_reset_02");
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_eviction();
    test_flush();
    test_flush_hit_race();
    test_done_exit();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
